// File: rtl/psubsb_seq_if.sv
// Start/done handshake bundle for the sequential packed saturating subtractor.
// The execute-stage controller holds the master side; the subtractor holds the slave side.
interface psubsb_seq_if #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
);
    logic                      start;
    logic [WIDTH-1:0]          A;
    logic [WIDTH-1:0]          B;
    logic                      busy;
    logic                      done;
    logic [WIDTH-1:0]          Diff;
    logic [WIDTH/LANE_W-1:0]   Ovf;
    logic                      Error;

    modport master (
        output start, A, B,
        input  busy, done, Diff, Ovf, Error
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, Ovf, Error
    );
endinterface

// File: rtl/psubsb_seq.sv
// Sequential packed saturating subtractor: one LANE_W-bit lane of A - B per cycle,
// LSB lane first, each lane clamped to its signed limit on overflow.
module psubsb_seq #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    psubsb_seq_if.slave  bus
);
    localparam int LANES = WIDTH / LANE_W;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    // Returns {overflow, saturated lane result}.
    function automatic logic [LANE_W:0] sat_sub(
        input logic signed [LANE_W-1:0] a,
        input logic signed [LANE_W-1:0] b
    );
        logic signed [LANE_W-1:0] d;
        logic                     ovf;
        logic [LANE_W-1:0]        res;
        d   = a - b;
        ovf = (a[LANE_W-1] != b[LANE_W-1]) && (d[LANE_W-1] != a[LANE_W-1]);
        if (!ovf)
            res = d;
        else if (!a[LANE_W-1])
            res = {1'b0, {(LANE_W-1){1'b1}}};
        else
            res = {1'b1, {(LANE_W-1){1'b0}}};
        return {ovf, res};
    endfunction

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                lane_q, lane_d;
    logic [LANES-1:0][LANE_W-1:0]    a_q, b_q;
    logic [LANES-1:0][LANE_W-1:0]    diff_q, diff_d;
    logic [LANES-1:0]                ovf_q, ovf_d;
    logic                            err_q, err_d;
    logic                            done_q, done_d;
    logic                            load_ops;
    logic [LANE_W-1:0]               lane_res;
    logic                            lane_ovf;

    assign {lane_ovf, lane_res} = sat_sub(a_q[lane_q], b_q[lane_q]);

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        diff_d   = diff_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        done_d   = 1'b0;
        load_ops = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load_ops = 1'b1;
                    diff_d   = '0;
                    ovf_d    = '0;
                    err_d    = 1'b0;
                    lane_d   = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                diff_d[lane_q] = lane_res;
                ovf_d[lane_q]  = lane_ovf;
                err_d          = err_q | lane_ovf;
                if (lane_q == IDX_W'(LANES - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    lane_d  = '0;
                end else begin
                    lane_d  = lane_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            diff_q  <= '0;
            ovf_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            diff_q  <= diff_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Operand holding registers only change on an accepted start, so they need no reset.
    always_ff @(posedge clk) begin
        if (load_ops) begin
            a_q <= bus.A;
            b_q <= bus.B;
        end
    end

    assign bus.busy  = (state_q == BUSY);
    assign bus.done  = done_q;
    assign bus.Diff  = diff_q;
    assign bus.Ovf   = ovf_q;
    assign bus.Error = err_q;
endmodule

// File: tb/tb_psubsb_seq.sv
// Testbench for psubsb_seq: directed and random packed subtracts against a lane-range model.
module tb_psubsb_seq;
    localparam int WIDTH  = 16;
    localparam int LANE_W = 4;
    localparam int LANES  = WIDTH / LANE_W;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    psubsb_seq_if #(.WIDTH(WIDTH), .LANE_W(LANE_W)) bus();

    psubsb_seq #(.WIDTH(WIDTH), .LANE_W(LANE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: true signed difference per lane, clamped to the lane's range.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [WIDTH-1:0] d, output logic [LANES-1:0] o);
        int maxv, minv, x, y, r;
        maxv = (1 << (LANE_W - 1)) - 1;
        minv = -(1 << (LANE_W - 1));
        d = '0;
        o = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [LANE_W-1:0] la, lb;
            logic [31:0]       rv;
            la = a[k*LANE_W +: LANE_W];
            lb = b[k*LANE_W +: LANE_W];
            x = int'($signed(la));
            y = int'($signed(lb));
            r = x - y;
            if (r > maxv) begin
                r = maxv; o[k] = 1'b1;
            end else if (r < minv) begin
                r = minv; o[k] = 1'b1;
            end
            rv = r;
            d[k*LANE_W +: LANE_W] = rv[LANE_W-1:0];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full operation with timing checks: busy for LANES cycles, then done with final results.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string name);
        logic [WIDTH-1:0] ed;
        logic [LANES-1:0] eo;
        model(a, b, ed, eo);
        bus.A = a; bus.B = b; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.A = $urandom; bus.B = $urandom;
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_phase cyc%0d: busy=%b done=%b, expected busy=1 done=0", name, i, bus.busy, bus.done);
            end
            step();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_cycle: busy=%b done=%b, expected busy=0 done=1", name, bus.busy, bus.done);
        end
        checks++;
        if (bus.Diff !== ed || bus.Ovf !== eo || bus.Error !== (|eo)) begin
            errors++;
            $display("FAIL %s result: Diff=%h Ovf=%b Error=%b, expected Diff=%h Ovf=%b Error=%b",
                     name, bus.Diff, bus.Ovf, bus.Error, ed, eo, |eo);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.Diff !== ed || bus.Ovf !== eo || bus.Error !== (|eo)) begin
            errors++;
            $display("FAIL %s hold: done=%b Diff=%h Ovf=%b, expected done=0 Diff=%h Ovf=%b",
                     name, bus.done, bus.Diff, bus.Ovf, ed, eo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Diff !== '0 || bus.Ovf !== '0 || bus.Error !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: busy=%b done=%b Diff=%h Ovf=%b Error=%b, expected all 0",
                         i, bus.busy, bus.done, bus.Diff, bus.Ovf, bus.Error);
            end
            step();
        end
    endtask

    task automatic test_directed();
        do_op(16'h1234, 16'h0111, "basic");
        do_op(16'h7000, 16'h8000, "pos_sat");
        do_op(16'h0008, 16'h0001, "neg_sat");
        do_op(16'h8787, 16'h1818, "all_ovf");
        do_op(16'h0000, 16'h0000, "zero");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            do_op(16'($urandom), 16'($urandom), "random");
    endtask

    task automatic test_back_to_back();
        bus.A = 16'h5555; bus.B = 16'h1111; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.A = 16'hFFFF; bus.B = 16'h0000; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step();
        checks++;
        if (bus.done !== 1'b1 || bus.Diff !== 16'h4444 || bus.Ovf !== 4'b0000 || bus.Error !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: done=%b Diff=%h Ovf=%b Error=%b, expected done=1 Diff=4444 Ovf=0000 Error=0",
                     bus.done, bus.Diff, bus.Ovf, bus.Error);
        end
        bus.A = 16'h0000; bus.B = 16'h0001; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b, expected busy=1 done=0", bus.busy, bus.done);
        end
        for (int i = 0; i < LANES; i++) step();
        checks++;
        if (bus.done !== 1'b1 || bus.Diff !== 16'h000F || bus.Ovf !== 4'b0000 || bus.Error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: done=%b Diff=%h Ovf=%b Error=%b, expected done=1 Diff=000f Ovf=0000 Error=0",
                     bus.done, bus.Diff, bus.Ovf, bus.Error);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int seen_done;
        bus.A = 16'h7000; bus.B = 16'h8000; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Diff !== '0 || bus.Ovf !== '0 || bus.Error !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b Diff=%h Ovf=%b Error=%b, expected all 0",
                     bus.busy, bus.done, bus.Diff, bus.Ovf, bus.Error);
        end
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
            step();
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: busy/done cycles=%0d, expected 0", seen_done);
        end
        bus.A = 16'h1234; bus.B = 16'h0111; bus.start = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_over_start: busy=%b, expected 0", bus.busy);
        end
        do_op(16'h1234, 16'h0111, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psubsb_seq.md
# psubsb_seq

Sequential packed saturating subtractor: computes A − B independently on each 4-bit two's-complement lane of a 16-bit word, one lane per cycle, LSB lane first, and clamps each overflowing lane to its signed limit. It is the subtract-direction counterpart of the packed saturating add in the ALU datapath. It serves multi-cycle packed-subtract operations through a start/done handshake with the execute-stage controller.

## Interface
- WIDTH, 16, total operand width; must be a multiple of LANE_W.
- LANE_W, 4, lane width in bits; number of lanes is WIDTH/LANE_W (4 at default).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; accepted only when busy is low.
- A  in  WIDTH  minuend; sampled only on an accepted start.
- B  in  WIDTH  subtrahend; sampled only on an accepted start.
- busy  out  1  high while lanes are being computed.
- done  out  1  one-cycle pulse; result is final.
- Diff  out  WIDTH  packed saturated difference.
- Ovf  out  WIDTH/LANE_W  per-lane overflow flags; bit k corresponds to lane k.
- Error  out  1  OR of all Ovf bits.

## Operation
- Internal state: IDLE and BUSY; lane index counter; A/B holding registers.
- On reset, busy, done, Diff, Ovf and Error are all 0, the state is IDLE and the lane index is 0.
- IDLE, start=1: latch A and B, clear Diff, Ovf and Error to 0, set lane index to 0, and go to BUSY.
- IDLE, start=0: all outputs hold their values.
- BUSY: each cycle, compute lane k of the latched operands, write it to Diff[k*LANE_W +: LANE_W], write Ovf[k], and OR Ovf[k] into Error.
  - After the last lane, go to IDLE and pulse done.
- BUSY, start=1: ignored. Latched operands are unaffected by changes to A and B while busy.
- Lane arithmetic, with a = A lane and b = B lane:
  - d = a − b, computed modulo 2^LANE_W.
  - Overflow = (a[MSB] ≠ b[MSB]) and (d[MSB] ≠ a[MSB]).
  - On overflow: lane result = 0111 if a[MSB] = 0 (positive − negative), else 1000.
  - Without overflow: lane result = d.
- Lanes never interact: no borrow propagates between lanes.
- Diff is only meaningful once done has pulsed. Partially filled values are visible while busy, and the bench must not check them.
- Diff, Ovf and Error hold their final values until the next accepted start or reset.
- Reset mid-operation: the operation is aborted, all outputs go to 0, done is never pulsed for it, and the block is back in IDLE on the next cycle.

## Timing
- Take cycle c as the cycle in which start=1 and busy=0 (the start is accepted at the end of c).
- busy is high in cycles c+1 through c+4 (four lanes).
- Lane k is registered at the end of cycle c+1+k.
- done is high only in cycle c+5. Diff, Ovf and Error are final in c+5.
- Latency from the accepting edge to the done pulse: 4 cycles (5 cycles from the start cycle to the done cycle).
- Back-to-back: a start in the done cycle c+5 is accepted; busy is high again in c+6, and done is not asserted in c+6.
- Throughput: one operation per 5 cycles.
- If start and rst are both high in the same cycle, rst wins.

## Test plan
- Reset, then hold idle: all outputs 0 and busy 0 for 10 cycles with start=0.
- A=0x1234, B=0x0111, one-cycle start: busy high for 4 cycles, done on the 5th cycle, Diff=0x1123, Ovf=0000, Error=0.
- Positive saturation, A=0x7000, B=0x8000: Diff=0x7000, Ovf=1000, Error=1.
- Negative saturation, A=0x0008, B=0x0001: Diff=0x0008, Ovf=0001, Error=1.
- All lanes overflowing, A=0x8787, B=0x1818: Diff=0x8787, Ovf=1111, Error=1.
- Handshake cases:
  - Start A=0x5555, B=0x1111.
  - Pulse start with A=0xFFFF while busy; it must be ignored, giving Diff=0x4444.
  - Issue a new start in the done cycle with A=0x0000, B=0x0001; the second done arrives exactly 5 cycles later with Diff=0x000F.
  - Separately, assert rst in the 2nd busy cycle: the next cycle shows busy=0, Diff=0, and done never pulses.
